// File: rtl/p_hit_pkg.sv
// p_hit_pkg: shared types for the p_hit hit-point datapath and its dispatcher.
package p_hit_pkg;
  localparam int DATA_W = 32;
  typedef logic signed [2:0][DATA_W-1:0] vec3_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} dispatch_state_t;
endpackage

// File: rtl/p_hit_tag_fifo.sv
// p_hit_tag_fifo: first-word-fall-through sync FIFO holding the tags of jobs inside p_hit.
module p_hit_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clock)
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/p_hit_dispatch.sv
// p_hit_dispatch: job sequencer for p_hit with in-flight bound, tag re-attach and flush/drain.
// Define P_HIT_DISPATCH_STATS_EN to add the stat_jobs/stat_stall/stat_bp counters.
module p_hit_dispatch
  import p_hit_pkg::*;
#(
  parameter int TAG_W        = 8,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  vec3_t                         in_tri_normal,
  input  vec3_t                         in_v0,
  input  vec3_t                         in_origin,
  input  vec3_t                         in_dir,
  input  logic [TAG_W-1:0]              in_tag,
  output vec3_t                         ph_tri_normal_1,
  output vec3_t                         ph_tri_normal_2,
  output vec3_t                         ph_v0,
  output vec3_t                         ph_origin_1,
  output vec3_t                         ph_origin_2,
  output vec3_t                         ph_dir_1,
  output vec3_t                         ph_dir_2,
  input  logic [3:0]                    ph_in_full,
  output logic [3:0]                    ph_in_wr_en,
  input  vec3_t                         ph_out,
  input  logic                          ph_out_empty,
  output logic                          ph_out_rd_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output vec3_t                         out_hit,
  output logic [TAG_W-1:0]              out_tag,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [$clog2(MAX_INFLIGHT):0] inflight
`ifdef P_HIT_DISPATCH_STATS_EN
  ,
  output logic [31:0]                   stat_jobs,
  output logic [31:0]                   stat_stall,
  output logic [31:0]                   stat_bp
`endif
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  dispatch_state_t state, state_nxt;
  logic accept, retire, tag_full, tag_empty;
  logic [TAG_W-1:0] tag_head;
  assign ph_tri_normal_1 = in_tri_normal;
  assign ph_tri_normal_2 = in_tri_normal;
  assign ph_v0 = in_v0;
  assign ph_origin_1 = in_origin;
  assign ph_origin_2 = in_origin;
  assign ph_dir_1 = in_dir;
  assign ph_dir_2 = in_dir;
  assign in_ready = (state == RUN) && !(|ph_in_full) && (inflight < CW'(MAX_INFLIGHT)) && !tag_full;
  assign accept = in_valid && in_ready;
  assign ph_in_wr_en = {4{accept}};
  // Only pop p_hit when its tag is known and the output register can take it.
  assign retire = !ph_out_empty && !tag_empty && (!out_valid || out_ready);
  assign ph_out_rd_en = retire;
  assign flush_done = state == DONE;
  p_hit_tag_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (accept),
    .wr_data(in_tag),
    .rd_en  (retire),
    .rd_data(tag_head),
    .full   (tag_full),
    .empty  (tag_empty)
  );
  always_comb
    state_nxt = (state == RUN)   ? (flush_req ? DRAIN : RUN) :
                (state == DRAIN) ? ((inflight == '0 && !out_valid) ? DONE : DRAIN) :
                RUN;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      inflight <= '0;
      out_valid <= 1'b0;
      out_hit <= '0;
      out_tag <= '0;
    end else begin
      state <= state_nxt;
      inflight <= inflight + CW'(accept) - CW'(retire);
      if (retire) begin
        out_valid <= 1'b1;
        out_hit <= ph_out;
        out_tag <= tag_head;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
  // A result without a matching tag means p_hit and the dispatcher lost sync.
  assert property (@(posedge clock) disable iff (reset) !(!ph_out_empty && tag_empty));
`ifdef P_HIT_DISPATCH_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_jobs <= '0;
      stat_stall <= '0;
      stat_bp <= '0;
    end else begin
      stat_jobs <= stat_jobs + 32'(accept);
      stat_stall <= stat_stall + 32'(in_valid && !in_ready);
      stat_bp <= stat_bp + 32'(out_valid && !out_ready);
    end
  end
`endif
endmodule

// File: tb/tb_p_hit_dispatch.sv
// tb_p_hit_dispatch: p_hit stub, job-queue reference model, table vectors and directed/random sequences.
module tb_p_hit_dispatch;
  import p_hit_pkg::*;
  logic clock = 0;
  logic reset = 1;
  logic in_valid = 0;
  logic in_ready;
  vec3_t in_tri_normal = '0, in_v0 = '0, in_origin = '0, in_dir = '0;
  logic [7:0] in_tag = '0;
  vec3_t ph_tri_normal_1, ph_tri_normal_2, ph_v0, ph_origin_1, ph_origin_2, ph_dir_1, ph_dir_2;
  logic [3:0] ph_in_full = '0;
  logic [3:0] ph_in_wr_en;
  vec3_t ph_out = '0;
  logic ph_out_empty = 1;
  logic ph_out_rd_en;
  logic out_valid;
  logic out_ready = 1;
  vec3_t out_hit;
  logic [7:0] out_tag;
  logic flush_req = 0;
  logic flush_done;
  logic [4:0] inflight;
`ifdef P_HIT_DISPATCH_STATS_EN
  logic [31:0] stat_jobs, stat_stall, stat_bp;
`endif

  p_hit_dispatch #(.TAG_W(8), .MAX_INFLIGHT(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_tri_normal(in_tri_normal), .in_v0(in_v0), .in_origin(in_origin), .in_dir(in_dir), .in_tag(in_tag),
    .ph_tri_normal_1(ph_tri_normal_1), .ph_tri_normal_2(ph_tri_normal_2), .ph_v0(ph_v0),
    .ph_origin_1(ph_origin_1), .ph_origin_2(ph_origin_2), .ph_dir_1(ph_dir_1), .ph_dir_2(ph_dir_2),
    .ph_in_full(ph_in_full), .ph_in_wr_en(ph_in_wr_en), .ph_out(ph_out), .ph_out_empty(ph_out_empty),
    .ph_out_rd_en(ph_out_rd_en), .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_tag(out_tag), .flush_req(flush_req), .flush_done(flush_done), .inflight(inflight)
`ifdef P_HIT_DISPATCH_STATS_EN
    , .stat_jobs(stat_jobs), .stat_stall(stat_stall), .stat_bp(stat_bp)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic vec3_t add3(input vec3_t a, input vec3_t b);
    vec3_t r;
    for (int k = 0; k < 3; k++) r[k] = a[k] + b[k];
    return r;
  endfunction

  // p_hit stub: in-order, per-job latency `lat`, `avail` results may leave (-1 = unlimited).
  typedef struct {vec3_t d; int rdy;} sent_t;
  sent_t sq[$];
  int cyc = 0, lat = 1, avail = -1;
  always @(posedge clock) begin
    cyc++;
    if (reset) sq.delete();
    else begin
      if (ph_out_rd_en && sq.size() > 0) begin
        void'(sq.pop_front());
        if (avail > 0) avail--;
      end
      if (ph_in_wr_en[0]) sq.push_back('{d: add3(ph_origin_1, ph_dir_2), rdy: cyc + lat});
    end
    ph_out_empty <= !(sq.size() > 0 && sq[0].rdy <= cyc && avail != 0);
    ph_out <= sq.size() > 0 ? sq[0].d : '0;
  end

  // Reference model: queue of accepted jobs (hit = origin + dir, tag), output slot, flush phase.
  typedef struct {vec3_t h; logic [7:0] t;} job_t;
  job_t m_q[$];
  bit m_ov = 0;
  vec3_t m_hit = '0;
  logic [7:0] m_tag = '0;
  int m_st = 0; // 0 accepting, 1 draining, 2 drained pulse

  function automatic logic e_ready();
    return m_st == 0 && ph_in_full == 4'h0 && m_q.size() < 16;
  endfunction
  function automatic logic e_rd();
    return !ph_out_empty && m_q.size() > 0 && (!m_ov || out_ready);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      m_ov = 0;
      m_st = 0;
    end else begin
      bit acc, ret;
      int nst;
      job_t j;
      acc = in_valid && e_ready();
      ret = e_rd();
      nst = m_st == 0 ? (flush_req ? 1 : 0) : m_st == 1 ? ((m_q.size() == 0 && !m_ov) ? 2 : 1) : 0;
      if (ret) begin
        j = m_q.pop_front();
        m_ov = 1;
        m_hit = j.h;
        m_tag = j.t;
      end else if (out_ready) m_ov = 0;
      if (acc) m_q.push_back('{h: add3(in_origin, in_dir), t: in_tag});
      m_st = nst;
    end
  end

  always @(negedge clock) begin
    if (chk_on && !reset) begin
      chk("in_ready", in_ready, e_ready());
      chk("wr_en", ph_in_wr_en, {4{in_valid && e_ready()}});
      chk("rd_en", ph_out_rd_en, e_rd());
      chk("inflight", inflight, m_q.size());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("out_hit", out_hit, m_hit);
        chk("out_tag", out_tag, m_tag);
      end
      chk("flush_done", flush_done, m_st == 2);
      if (in_valid)
        chk("pass_through",
            {ph_tri_normal_1, ph_tri_normal_2, ph_v0, ph_origin_1, ph_origin_2, ph_dir_1, ph_dir_2} ==
            {in_tri_normal, in_tri_normal, in_v0, in_origin, in_origin, in_dir, in_dir}, 1'b1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_job(input logic [7:0] t);
    in_tag = t;
    for (int k = 0; k < 3; k++) begin
      in_tri_normal[k] = $urandom;
      in_v0[k] = $urandom;
      in_origin[k] = $urandom;
      in_dir[k] = $urandom;
    end
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while ((inflight != 0 || out_valid) && i < max) begin
      step();
      i++;
    end
    chk("idle_timeout", i < max, 1'b1);
  endtask

  typedef struct {logic v; logic [3:0] f; logic rdy; logic [3:0] wr;} vec_t;
  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, pops, pulses;
    vec3_t e, h5;
    logic [7:0] t5;
    logic [7:0] got[$];
    tbl[0] = '{1'b1, 4'h0, 1'b1, 4'hF};
    tbl[1] = '{1'b0, 4'h0, 1'b1, 4'h0};
    tbl[2] = '{1'b1, 4'h1, 1'b0, 4'h0};
    tbl[3] = '{1'b1, 4'h2, 1'b0, 4'h0};
    tbl[4] = '{1'b1, 4'h4, 1'b0, 4'h0};
    tbl[5] = '{1'b1, 4'h8, 1'b0, 4'h0};
    tbl[6] = '{1'b0, 4'hF, 1'b0, 4'h0};
    tbl[7] = '{1'b1, 4'hF, 1'b0, 4'h0};

    // Reset state
    repeat (2) step();
    chk_on = 1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_inflight", inflight, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_rd_en", ph_out_rd_en, 1'b0);
    reset = 0;
    #1 chk("rst_in_ready", in_ready, 1'b1);

    // Combinational accept table
    for (int i = 0; i < 8; i++) begin
      step();
      in_valid = tbl[i].v;
      ph_in_full = tbl[i].f;
      set_job(8'(i));
      #1;
      chk("tbl_ready", in_ready, tbl[i].rdy);
      chk("tbl_wr", ph_in_wr_en, tbl[i].wr);
      in_valid = 0;
      ph_in_full = 0;
    end

    // Single job, tag 0x5A, 10-cycle p_hit latency
    lat = 10;
    step();
    set_job(8'h5A);
    in_origin = '0;
    in_dir = '0;
    in_origin[0] = 1;
    in_origin[1] = 2;
    in_origin[2] = 3;
    e = in_origin;
    in_valid = 1;
    #1 chk("one_wr", ph_in_wr_en, 4'hF);
    step();
    in_valid = 0;
    #1;
    chk("one_wr_drop", ph_in_wr_en, 4'h0);
    chk("one_inflight1", inflight, 1);
    pops = 0;
    for (int i = 0; i < 30 && !out_valid; i++) begin
      pops = ph_out_rd_en;
      step();
    end
    chk("one_timeout", out_valid, 1'b1);
    chk("one_rd_before", pops, 1);
    chk("one_hit", out_hit, e);
    chk("one_tag", out_tag, 8'h5A);
    chk("one_inflight0", inflight, 0);
    step();
    chk("one_valid_drop", out_valid, 1'b0);

    // 20 back-to-back jobs, p_hit holds results
    lat = 1;
    avail = 0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      in_valid = 1;
      set_job(8'($urandom));
      #1 acc += int'(in_ready);
    end
    step();
    #1;
    chk("bp_accepts", acc, 16);
    chk("bp_ready", in_ready, 1'b0);
    chk("bp_inflight", inflight, 16);
    avail = 1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      set_job(8'($urandom));
      #1 acc += int'(in_ready);
    end
    chk("bp_one_slot", acc, 1);
    step();
    in_valid = 0;
    avail = -1;
    wait_idle(100);

    // Full flag on one lane blocks all four
    step();
    set_job(8'h33);
    in_valid = 1;
    ph_in_full = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_ready", in_ready, 1'b0);
      chk("full_wr", ph_in_wr_en, 4'h0);
      step();
    end
    ph_in_full = 0;
    #1 chk("full_release_wr", ph_in_wr_en, 4'hF);
    step();
    in_valid = 0;
    wait_idle(50);

    // Output back-pressure with 3 results queued
    lat = 2;
    out_ready = 0;
    pops = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      in_valid = i < 3;
      if (i < 3) set_job(8'(i + 1));
      #1 pops += int'(ph_out_rd_en);
      if (i == 5) begin
        h5 = out_hit;
        t5 = out_tag;
      end
    end
    chk("hold_pops", pops, 1);
    chk("hold_hit", out_hit, h5);
    chk("hold_tag", out_tag, t5);
    chk("hold_tag1", out_tag, 8'd1);
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      #1 if (out_valid) got.push_back(out_tag);
      step();
    end
    chk("order_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("order_tag", got[i], 8'(i + 1));

    // Flush with 4 jobs in flight
    lat = 8;
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid = 1;
      set_job(8'($urandom));
    end
    step();
    in_valid = 0;
    flush_req = 1;
    #1 chk("flush_inflight", inflight, 4);
    step();
    in_valid = 1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (flush_done) begin
        pulses++;
        flush_req = 0;
        in_valid = 0;
      end else if (pulses == 0) chk("flush_ready", in_ready, 1'b0);
      step();
    end
    chk("flush_pulses", pulses, 1);
    chk("flush_ready_back", in_ready, 1'b1);

    // Reset with 5 in flight
    lat = 50;
    for (int i = 0; i < 5; i++) begin
      step();
      in_valid = 1;
      set_job(8'($urandom));
    end
    step();
    in_valid = 0;
    #1 chk("rst5_inflight", inflight, 5);
    reset = 1;
    step();
    reset = 0;
    #1;
    chk("rst5_inflight0", inflight, 0);
    chk("rst5_out_valid", out_valid, 1'b0);
    chk("rst5_ready", in_ready, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid = ($urandom % 4) != 0;
      set_job(8'($urandom));
      ph_in_full = ($urandom % 8 == 0) ? 4'($urandom) : 4'h0;
      out_ready = ($urandom % 4) != 0;
      flush_req = ($urandom % 40) == 0 ? 1'b1 : (flush_req && ($urandom % 3 != 0));
      lat = $urandom_range(1, 6);
      avail = ($urandom % 16 == 0) ? 0 : -1;
    end
    step();
    in_valid = 0;
    ph_in_full = 0;
    flush_req = 0;
    out_ready = 1;
    avail = -1;
    wait_idle(200);
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
